fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Read-side drain engine for the team's synchronous FIFO.
- Issues FIFO read strobes and absorbs the FIFO's one-cycle read latency.
- Presents popped words on a valid/ready stream to downstream logic.
- A 3-entry output buffer sustains one word per cycle under back-pressure, with no combinational path from m_ready to fifo_rd_en.

Parameters:
- FIFO_WIDTH, 8, data word width; matches the FIFO's data width.
- CNT_WIDTH, 16, width of the delivered-word statistics counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rstN  input  1  reset, asynchronous assert, active low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  FIFO_WIDTH  FIFO data_out; valid the cycle after an accepted read.
- fifo_rd_en  output  1  read strobe to the FIFO.
- m_valid  output  1  stream word available.
- m_ready  input  1  downstream accepts the word.
- m_data  output  FIFO_WIDTH  stream word (buffer head).
- flush  input  1  synchronous discard of buffered and in-flight words.
- busy  output  1  buffer non-empty or a read is in flight.
- words_out  output  CNT_WIDTH  count of stream transfers.

Behaviour:
Interface decision: one clock, clk. Reset rstN is asynchronous and active-low.

Reset (rstN low):
- occ=0, inflight=0, head/tail ptrs=0, words_out=0.
- m_valid=0, m_data=0, busy=0.
- fifo_rd_en forced 0, gated directly by rstN.

Read issue:
- fifo_rd_en = !fifo_empty && !flush && (occ + inflight) < 3.
- Depends only on registered state and fifo_empty.

In-flight tracking:
- inflight is registered: it takes the value of fifo_rd_en at each edge.

Capture:
- If inflight=1 and flush=0 at an edge, write fifo_rdata into the entry at tail.
- tail advances mod 3.

Output:
- m_valid = (occ != 0).
- m_data = entry[head].
- Transfer when m_valid && m_ready: head advances mod 3 and words_out increments, wrapping at 2^CNT_WIDTH.
- Simultaneous capture and transfer leaves occ unchanged.
- occ never exceeds 3. Capture into a full buffer is impossible by the issue rule; an assertion checks this.

Latency and throughput:
- Read issued in cycle t: word visible on m_data/m_valid in cycle t+2.
- With m_ready held high and the FIFO non-empty: steady state is one word per cycle (occ=1, inflight=1).

Back-pressure:
- m_data and m_valid stay stable while m_valid && !m_ready.
- Issue stops once occ + inflight = 3.

Flush (sampled at posedge):
- occ=0, head=tail=0, inflight=0.
- The in-flight word arriving that edge is dropped.
- fifo_rd_en is 0 during the flush cycle.
- A transfer in the flush cycle does not count.
- words_out is not cleared.

fifo_empty rising while a read is in flight: the in-flight word is still captured.

busy = (occ != 0) || inflight.

Reset asserted mid-stream: all state clears immediately. Buffered words are lost; the FIFO's own pointers are its responsibility.

Decomposition:
- Package fifo_rd_pkg holds:
  - localparam OBUF_ENTRIES=3;
  - typedef obuf_ptr_t (2-bit);
  - typedef obuf_occ_t (2-bit, 0..3).
- One natural sub-module, fifo_rd_obuf: 3-entry circular buffer with push/pop/clear, exposing occ and head data.
- The top contains issue logic, inflight register, counter and flush gating.

Test Plan:
- Reset then fifo_empty=1 for 10 cycles -> fifo_rd_en=0, m_valid=0, busy=0, words_out=0.
- Preload FIFO with 0x11,0x22,0x33,0x44; m_ready=1 -> rd_en at cycles 0..3; m_data 0x11..0x44 on cycles 2..5 back-to-back; words_out=4.
- Same preload, m_ready=0 -> exactly 3 rd_en pulses, occ=3, m_data stable at 0x11. Then raise m_ready -> remaining word read, order 0x11,0x22,0x33,0x44 preserved.
- Assert flush in the cycle after a read issue with occ=2 -> m_valid=0 next cycle, in-flight word dropped, next delivered word is the following FIFO entry.
- Random m_ready (50%) over 200 FIFO words 0..199 -> output sequence identical and in order; words_out=200; m_data stable under stall.
- Drop rstN mid-stream with occ=2 -> m_valid, busy, fifo_rd_en=0 asynchronously; words_out=0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_rd_pkg;

    localparam int unsigned OBUF_ENTRIES = 3;

    typedef logic [1:0] obuf_ptr_t;
    typedef logic [1:0] obuf_occ_t;

    // Circular pointer increment over the three buffer entries.
    function automatic obuf_ptr_t ptr_next(input obuf_ptr_t p);
        return (p == obuf_ptr_t'(OBUF_ENTRIES - 1)) ? '0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Three-entry circular output buffer with push, pop and synchronous clear.
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output obuf_occ_t        occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [OBUF_ENTRIES];
    obuf_ptr_t        head;
    obuf_ptr_t        tail;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < OBUF_ENTRIES; i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (clear) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[head];

    // The issue rule keeps occ + inflight <= 3, so a capture never meets a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstN)
        (push && !clear) |-> (occ != 2'd3));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads, absorbs the one-cycle read latency, streams words out.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_out
);

    obuf_occ_t  occ;
    logic       inflight;
    logic [2:0] pending;
    logic       capture;
    logic       xfer;

    // Issue depends only on registered occupancy/inflight, never on m_ready.
    assign pending    = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en = rstN && !fifo_empty && !flush && (pending < 3'(OBUF_ENTRIES));

    assign m_valid = (occ != '0);
    assign capture = inflight && !flush;
    assign xfer    = m_valid && m_ready && !flush;
    assign busy    = m_valid || inflight;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            inflight  <= 1'b0;
            words_out <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (xfer) begin
                words_out <= words_out + 1'b1;
            end
        end
    end

    fifo_rd_obuf #(
        .WIDTH (FIFO_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rstN      (rstN),
        .clear     (flush),
        .push      (capture),
        .push_data (fifo_rdata),
        .pop       (xfer),
        .occ       (occ),
        .head_data (m_data)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a simple behavioural FIFO.
module tb_fifo_stream_reader;

    logic        clk;
    logic        rstN;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        flush;
    logic        busy;
    logic [15:0] words_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fmem [1024];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    fifo_stream_reader #(
        .FIFO_WIDTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .flush      (flush),
        .busy       (busy),
        .words_out  (words_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_rdata <= fmem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic push_word(input logic [7:0] d);
        fmem[wr_ptr] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset;
        rstN = 1'b0; m_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h expected %h", m_data, 8'h00); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b expected 0", fifo_rd_en); end
        rstN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en c%0d got %b expected 0", c, fifo_rd_en); end
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_m_valid c%0d got %b expected 0", c, m_valid); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", busy); end
        checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL idle_words_out got %0d expected 0", words_out); end
    endtask

    task automatic test_stream;
        logic exp_rd, exp_v;
        logic [7:0] exp_d;
        @(negedge clk);
        m_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_rd = (c < 4);
            exp_v  = (c >= 2) && (c <= 5);
            exp_d  = 8'(8'h11 * (c - 1));
            checks++; if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL stream_rd_en c%0d got %b expected %b", c, fifo_rd_en, exp_rd); end
            checks++; if (m_valid !== exp_v) begin errors++; $display("FAIL stream_m_valid c%0d got %b expected %b", c, m_valid, exp_v); end
            if (exp_v) begin
                checks++; if (m_data !== exp_d) begin errors++; $display("FAIL stream_m_data c%0d got %h expected %h", c, m_data, exp_d); end
            end
        end
        checks++; if (words_out !== 16'd4) begin errors++; $display("FAIL stream_words_out got %0d expected 4", words_out); end
    endtask

    task automatic test_backpressure;
        int pulses = 0;
        int got = 0;
        int n = 0;
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;
        @(negedge clk);
        m_ready = 1'b0;
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (fifo_rd_en === 1'b1) pulses++;
            if (c >= 2) begin
                checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid c%0d got %b expected 1", c, m_valid); end
                checks++; if (m_data !== 8'h11) begin errors++; $display("FAIL bp_m_data c%0d got %h expected 11", c, m_data); end
            end
        end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL bp_rd_pulses got %0d expected 3", pulses); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b expected 1", busy); end
        @(negedge clk);
        m_ready = 1'b1;
        while (got < 4 && n < 20) begin
            #1;
            if (m_valid === 1'b1) begin
                checks++; if (m_data !== exp_seq[got]) begin errors++; $display("FAIL bp_order idx%0d got %h expected %h", got, m_data, exp_seq[got]); end
                got++;
            end
            @(negedge clk);
            n++;
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_drain_count got %0d expected 4", got); end
        #1;
        checks++; if (words_out !== 16'd8) begin errors++; $display("FAIL bp_words_out got %0d expected 8", words_out); end
    endtask

    task automatic test_flush;
        int got = 0;
        int n = 0;
        logic [7:0] exp_seq [2];
        exp_seq[0] = 8'hA3; exp_seq[1] = 8'hA4;
        @(negedge clk);
        m_ready = 1'b0;
        push_word(8'hA0); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3); push_word(8'hA4);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flush_setup_rd_en c%0d got %b expected 1", c, fifo_rd_en); end
        end
        @(negedge clk);
        flush = 1'b1; m_ready = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en got %b expected 0", fifo_rd_en); end
        checks++; if (m_data !== 8'hA0) begin errors++; $display("FAIL flush_pre_m_data got %h expected a0", m_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b expected 1", busy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid got %b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b expected 0", busy); end
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flush_post_rd_en got %b expected 1", fifo_rd_en); end
        checks++; if (words_out !== 16'd8) begin errors++; $display("FAIL flush_words_out got %0d expected 8", words_out); end
        while (got < 2 && n < 20) begin
            @(negedge clk); #1;
            if (m_valid === 1'b1) begin
                checks++; if (m_data !== exp_seq[got]) begin errors++; $display("FAIL flush_next_word idx%0d got %h expected %h", got, m_data, exp_seq[got]); end
                got++;
            end
            n++;
        end
        checks++; if (got !== 2) begin errors++; $display("FAIL flush_drain_count got %0d expected 2", got); end
        @(negedge clk); #1;
        checks++; if (words_out !== 16'd10) begin errors++; $display("FAIL flush_final_words_out got %0d expected 10", words_out); end
    endtask

    task automatic test_random;
        int got = 0;
        int n = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] exp_d;
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 200; i++) push_word(8'(i));
        while (got < 200 && n < 3000) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                checks++; if (m_valid !== 1'b1 || m_data !== prev_data) begin errors++; $display("FAIL rand_stall_stable got v=%b d=%h expected v=1 d=%h", m_valid, m_data, prev_data); end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                exp_d = 8'(got);
                checks++; if (m_data !== exp_d) begin errors++; $display("FAIL rand_order idx%0d got %h expected %h", got, m_data, exp_d); end
                got++;
            end
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_data  = m_data;
            n++;
        end
        checks++; if (got !== 200) begin errors++; $display("FAIL rand_count got %0d expected 200", got); end
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        checks++; if (words_out !== 16'd210) begin errors++; $display("FAIL rand_words_out got %0d expected 210", words_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy_end got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int got = 0;
        int n = 0;
        @(negedge clk);
        m_ready = 1'b0;
        push_word(8'hB0); push_word(8'hB1); push_word(8'hB2); push_word(8'hB3);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_m_valid got %b expected 1", m_valid); end
        #1;
        rstN = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid got %b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b expected 0", busy); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rmid_rd_en got %b expected 0", fifo_rd_en); end
        checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL rmid_words_out got %0d expected 0", words_out); end
        @(negedge clk);
        rstN = 1'b1;
        m_ready = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rmid_resume_rd_en got %b expected 1", fifo_rd_en); end
        while (got < 1 && n < 20) begin
            @(negedge clk); #1;
            if (m_valid === 1'b1) begin
                checks++; if (m_data !== 8'hB3) begin errors++; $display("FAIL rmid_next_word got %h expected b3", m_data); end
                got++;
            end
            n++;
        end
        checks++; if (got !== 1) begin errors++; $display("FAIL rmid_drain_count got %0d expected 1", got); end
        @(negedge clk); #1;
        checks++; if (words_out !== 16'd1) begin errors++; $display("FAIL rmid_final_words_out got %0d expected 1", words_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
